uart_alu: RTL and testbench
===========================

# uart_alu

Serial-controlled 8-bit ALU: receives two operands and an opcode over a UART RX line, computes the result, and transmits it back as one UART byte on the TX line. Top-level FPGA block (Basys3-class, 50 MHz clock) between a host serial link and an internal ALU. It contains the baud generator, RX, TX, control FSM and ALU.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate; one bit = 5208 clocks at 50 MHz.
- `OVERSAMPLE`, 16: RX ticks per bit.
- `DATA_W`, 8: operand, result and frame data width.
- `i_clk`  in  1  system clock, rising edge.
- `i_reset`  in  1  reset, asynchronous, active-low.
- `i_rx`  in  1  UART serial input, idle high; 8N1, LSB first.
- `o_tx`  out  1  UART serial output, idle high; 8N1, LSB first.

## Operation
- Baud generator: free-running counter producing a 1-clock `tick` every round(CLK_FREQ/(BAUD*OVERSAMPLE)) = 326 clocks.
- RX FSM: IDLE, START, DATA, STOP.
  - A falling `i_rx` moves to START.
  - At tick 8 the line is re-sampled. If still low, go to DATA; if high, treat as a glitch and return to IDLE.
  - In DATA, sample every 16 ticks, 8 bits, shifting in LSB first.
  - In STOP, sample at 16 ticks.
    - Line high: pulse `rx_done` for 1 clock with the byte.
    - Line low (framing error): discard the byte, no `rx_done`.
  - Return to IDLE.
- Control FSM: GET_A, GET_B, GET_OP, SEND.
  - Each `rx_done` latches the byte into A, then B, then OP, in that order.
  - Latching OP moves to SEND, which asserts `tx_start` with the ALU result, then returns to GET_A.
- ALU opcodes (purely combinational, 8-bit, results wrap modulo 256, no flags):
  - ADD 0x20: A+B.
  - SUB 0x22: A−B.
  - AND 0x24: A&B.
  - OR 0x25: A|B.
  - XOR 0x26: A^B.
  - NOR 0x27: ~(A|B).
  - SRL 0x02: A>>B, logical.
  - SRA 0x03: A>>>B, sign-filling.
  - Shift amount is the full B. B≥8 gives 0x00 for SRL, and 0x00 or 0xFF by sign for SRA.
  - Any other opcode gives result 0x00, which is still transmitted.
- TX FSM: IDLE, START, DATA, STOP. Each bit lasts 16 ticks; LSB first; one stop bit.
  - `tx_start` while TX is busy is ignored.
  - The protocol guarantees TX finishes before the next result is ready (3 bytes of RX).
- RX operates continuously, including while TX is busy (full duplex).

## Timing
- Reset (async assert, sync release):
  - All FSMs to IDLE / GET_A.
  - A, B, OP and shift registers cleared to 0.
  - `o_tx`=1; baud counter 0.
- `rx_done` fires in the clock after the stop-bit mid-sample. This is about 9.5 bit periods after the start edge.
- Latency from OP `rx_done` to `o_tx` falling (start bit) is ≤ 3 clocks plus ≤ 1 tick period of alignment.
- TX frame length is exactly 10×16 ticks = 52160 clocks (±326).
- Reset mid-frame aborts RX and TX immediately: `o_tx` returns high and the partial operand set is discarded.
- A framing error does not advance the control FSM; the next valid byte fills the same slot.
- Baud tolerance: bytes sent at the nominal 104167 ns/bit must be received error-free.

## Structure
- Package `uart_alu_pkg`:
  - opcode constants (ADD, SUB, AND, OR, XOR, NOR, SRL, SRA);
  - state encodings for the RX, TX and control FSMs;
  - `DATA_W` and the default baud/clock constants.
- One natural sub-module: `alu` (combinational, inputs A/B/OP, output result).
- Baud generator, RX, TX and control FSM stay in the top-level as separate always blocks.

## Test plan
- Send 0x80, 0x80, 0x20 (ADD) -> `o_tx` transmits one frame with data 0x00 (wrap).
- Send 0x05, 0x03, 0x22 (SUB) -> result 0x02; then 0x03, 0x05, 0x22 -> 0xFE.
- Send 0x80, 0x01, 0x03 (SRA) -> 0xC0; then 0x80, 0x01, 0x02 (SRL) -> 0x40.
- Send 0x80, 0x80, 0x04 (undefined opcode) -> transmits 0x00; the next triple 0x0F, 0xF0, 0x27 (NOR) -> 0x00; 0x0F, 0xF0, 0x25 (OR) -> 0xFF.
- Byte with stop bit held low, then 0x12, 0x34, 0x20 -> the bad byte is ignored and the result is 0x46.
- Assert `i_reset` low mid-way through the second operand byte -> `o_tx`=1 immediately; after release, 0x01, 0x02, 0x20 -> 0x03.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared constants, opcodes and FSM state encodings for the serial-controlled ALU.
package uart_alu_pkg;

  localparam int DATA_W         = 8;
  localparam int CLK_FREQ_DEF   = 50_000_000;
  localparam int BAUD_DEF       = 9600;
  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {CTL_GET_A, CTL_GET_B, CTL_GET_OP, CTL_SEND} ctl_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_alu_alu.sv
// Combinational ALU: wrapping arithmetic, bitwise ops and full-width shifts; no flags.
module alu
  import uart_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_op,
  output logic [W-1:0] o_result
);

  localparam int SH_W = $clog2(W);

  logic w_big_shift;
  assign w_big_shift = (i_b > W'(W - 1));

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SRL:  o_result = w_big_shift ? '0 : (i_a >> i_b[SH_W-1:0]);
      OP_SRA:  o_result = w_big_shift ? {W{i_a[W-1]}}
                                      : $unsigned($signed(i_a) >>> i_b[SH_W-1:0]);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/uart_alu.sv
// UART-controlled ALU: receives A, B, OP bytes on i_rx and transmits the result byte on o_tx.
module uart_alu
  import uart_alu_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_W     = uart_alu_pkg::DATA_W
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  output logic o_tx
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int BCNT_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TCNT_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_W);
  localparam logic [BCNT_W-1:0] BAUD_LAST = BCNT_W'(BAUD_DIV - 1);
  localparam logic [TCNT_W-1:0] LAST_TICK = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TCNT_W-1:0] MID_TICK  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

  // NOTE: reset asserts asynchronously but releases on a clock edge, so no
  // flop sees a release too close to its active edge.
  logic r_rst_meta, r_rst_n;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) {r_rst_meta, r_rst_n} <= 2'b00;
    else          {r_rst_meta, r_rst_n} <= {1'b1, r_rst_meta};
  end

  logic [BCNT_W-1:0] r_baud_cnt;
  logic              r_tick;
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_baud_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_baud_cnt == BAUD_LAST) begin
      r_baud_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
      r_tick     <= 1'b0;
    end
  end

  // Line synchroniser plus previous sample for falling-edge detection.
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  always_ff @(posedge i_clk or negedge r_rst_n) begin
    if (!r_rst_n) {r_rx_meta, r_rx_sync, r_rx_prev} <= 3'b111;
    else          {r_rx_meta, r_rx_sync, r_rx_prev} <= {i_rx, r_rx_meta, r_rx_sync};
  end

  rx_state_t         r_rx_state, w_rx_state;
  logic [TCNT_W-1:0] r_rx_cnt, w_rx_cnt;
  logic [BIT_W-1:0]  r_rx_bit, w_rx_bit;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift;
  logic              r_rx_done, w_rx_done;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_done  = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (r_rx_prev && !r_rx_sync) begin
        w_rx_state = RX_START;
        w_rx_cnt   = '0;
      end
      RX_START: if (r_tick) begin
        if (r_rx_cnt == MID_TICK) begin
          w_rx_cnt   = '0;
          w_rx_bit   = '0;
          w_rx_state = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: if (r_tick) begin
        if (r_rx_cnt == LAST_TICK) begin
          w_rx_cnt   = '0;
          w_rx_shift = {r_rx_sync, r_rx_shift[DATA_W-1:1]};
          if (r_rx_bit == LAST_BIT) w_rx_state = RX_STOP;
          else                      w_rx_bit   = r_rx_bit + 1'b1;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: if (r_tick) begin
        if (r_rx_cnt == LAST_TICK) begin
          w_rx_cnt   = '0;
          w_rx_done  = r_rx_sync;  // low stop bit: framing error, byte dropped
          w_rx_state = RX_IDLE;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_done  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
      r_rx_done  <= w_rx_done;
    end
  end

  ctl_state_t        r_ctl_state, w_ctl_state;
  logic [DATA_W-1:0] r_a, r_b, r_op, w_a, w_b, w_op;
  logic              w_tx_start;
  logic [DATA_W-1:0] w_result;

  always_comb begin
    w_ctl_state = r_ctl_state;
    w_a         = r_a;
    w_b         = r_b;
    w_op        = r_op;
    w_tx_start  = 1'b0;
    case (r_ctl_state)
      CTL_GET_A:  if (r_rx_done) begin w_a  = r_rx_shift; w_ctl_state = CTL_GET_B;  end
      CTL_GET_B:  if (r_rx_done) begin w_b  = r_rx_shift; w_ctl_state = CTL_GET_OP; end
      CTL_GET_OP: if (r_rx_done) begin w_op = r_rx_shift; w_ctl_state = CTL_SEND;   end
      CTL_SEND: begin
        w_tx_start  = 1'b1;
        w_ctl_state = CTL_GET_A;
      end
      default: w_ctl_state = CTL_GET_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_ctl_state <= CTL_GET_A;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
    end else begin
      r_ctl_state <= w_ctl_state;
      r_a         <= w_a;
      r_b         <= w_b;
      r_op        <= w_op;
    end
  end

  alu #(.W(DATA_W)) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_result(w_result)
  );

  tx_state_t         r_tx_state, w_tx_state;
  logic [TCNT_W-1:0] r_tx_cnt, w_tx_cnt;
  logic [BIT_W-1:0]  r_tx_bit, w_tx_bit;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift;
  logic              r_tx, w_tx;

  // The line level is registered and changes together with the state.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_tx       = r_tx;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx = 1'b1;
        if (w_tx_start) begin
          w_tx_shift = w_result;
          w_tx_cnt   = '0;
          w_tx_state = TX_START;
          w_tx       = 1'b0;
        end
      end
      TX_START: if (r_tick) begin
        if (r_tx_cnt == LAST_TICK) begin
          w_tx_cnt   = '0;
          w_tx_bit   = '0;
          w_tx_state = TX_DATA;
          w_tx       = r_tx_shift[0];
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: if (r_tick) begin
        if (r_tx_cnt == LAST_TICK) begin
          w_tx_cnt = '0;
          if (r_tx_bit == LAST_BIT) begin
            w_tx_state = TX_STOP;
            w_tx       = 1'b1;
          end else begin
            w_tx_bit   = r_tx_bit + 1'b1;
            w_tx_shift = r_tx_shift >> 1;
            w_tx       = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: if (r_tick) begin
        if (r_tx_cnt == LAST_TICK) begin
          w_tx_cnt   = '0;
          w_tx_state = TX_IDLE;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_tx       <= w_tx;
    end
  end

  assign o_tx = r_tx;

endmodule

// File: tb/tb_uart_alu.sv
// Bench for uart_alu: drives serial triples, decodes TX frames and checks them against an ALU model.
module tb_uart_alu;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 25_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 64;  // 4 clocks per tick * 16 ticks

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_alu #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .DATA_W    (8)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .i_rx   (rx),
    .o_tx   (tx)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned op_stop_cyc = 0;
  logic [7:0]  exp_q[$];
  bit          mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference ALU written as plain integer arithmetic.
  function automatic int model(input int a, input int b, input int op);
    int sa, v;
    case (op)
      'h20: return (a + b) % 256;
      'h22: return (a - b + 256) % 256;
      'h24: return a & b;
      'h25: return a | b;
      'h26: return a ^ b;
      'h27: return 255 - (a | b);
      'h02: return (b >= 8) ? 0 : a / (2 ** b);
      'h03: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) return (sa < 0) ? 255 : 0;
        v = sa;
        for (int i = 0; i < b; i++) v = (v < 0) ? (v - 1) / 2 : v / 2;
        return (v + 256) % 256;
      end
      default: return 0;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit good_stop, input bit is_op);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (is_op) op_stop_cyc = cyc;
    rx = good_stop;
    repeat (BIT_CLKS) @(negedge clk);
    if (!good_stop) begin
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end
    repeat ($urandom_range(0, 8)) @(negedge clk);
  endtask

  // lit >= 0 pins the model to a hand-computed value and is what the DUT must send.
  task automatic send_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int lit);
    int e;
    e = model(a, b, op);
    if (lit >= 0) begin
      check($sformatf("model_%02h_%02h_%02h", a, b, op), e, lit);
      e = lit;
    end
    exp_q.push_back(8'(e));
    send_byte(a, 1'b1, 1'b0);
    send_byte(b, 1'b1, 1'b0);
    send_byte(op, 1'b1, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("frames_drained", exp_q.size(), 0);
  endtask

  // Frame decoder: samples each bit near its centre from the falling start edge.
  initial begin
    logic [7:0] d;
    int lat;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        mon_busy = 1'b1;
        lat = int'(cyc - op_stop_cyc);
        check($sformatf("tx_latency_%0d_in_window", lat), int'(lat >= 28 && lat <= 48), 1);
        repeat (BIT_CLKS / 2 - 1) @(negedge clk);
        check("tx_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          d[i] = tx;
        end
        repeat (BIT_CLKS) @(negedge clk);
        check("tx_stop_bit", tx, 1);
        check("tx_frame_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("tx_data", d, exp_q.pop_front());
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};
    logic [7:0] a, b, op, partial;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_tx_high", tx, 1);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("idle_tx_high", tx, 1);

    check("model_sra_b8_neg", model(8'h80, 8, 8'h03), 8'hFF);
    check("model_sra_b9_pos", model(8'h7F, 9, 8'h03), 8'h00);
    check("model_srl_b8", model(8'hFF, 8, 8'h02), 8'h00);

    send_triple(8'h80, 8'h80, 8'h20, 8'h00);
    send_triple(8'h05, 8'h03, 8'h22, 8'h02);
    send_triple(8'h03, 8'h05, 8'h22, 8'hFE);
    send_triple(8'h80, 8'h01, 8'h03, 8'hC0);
    send_triple(8'h80, 8'h01, 8'h02, 8'h40);
    send_triple(8'h80, 8'h80, 8'h04, 8'h00);
    send_triple(8'h0F, 8'hF0, 8'h27, 8'h00);
    send_triple(8'h0F, 8'hF0, 8'h25, 8'hFF);
    send_triple(8'h80, 8'h08, 8'h03, 8'hFF);
    send_triple(8'hFF, 8'h08, 8'h02, 8'h00);
    send_triple(8'hF0, 8'h3C, 8'h26, 8'hCC);

    // Framing error: byte with low stop bit must not fill a slot.
    send_byte(8'hA5, 1'b0, 1'b0);
    send_triple(8'h12, 8'h34, 8'h20, 8'h46);

    // Reset halfway through operand B discards the partial set.
    wait_drain();
    send_byte(8'h55, 1'b1, 1'b0);
    partial = 8'hC3;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame_tx_high", tx, 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_held_tx_high", tx, 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_triple(8'h01, 8'h02, 8'h20, 8'h03);

    for (int n = 0; n < 12; n++) begin
      a  = 8'($urandom_range(0, 255));
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : ops[$urandom_range(0, 7)];
      b  = (op == 8'h02 || op == 8'h03) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      send_triple(a, b, op, -1);
    end

    wait_drain();
    repeat (100) @(negedge clk);
    check("final_tx_idle", tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
